// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared funct3 encodings, FSM states and byte-lane mask constants
//            for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // funct3 width/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  localparam logic [3:0] MASK_NONE    = 4'b0000;
  localparam logic [3:0] MASK_BYTE0   = 4'b0001;
  localparam logic [3:0] MASK_LO_HALF = 4'b0011;
  localparam logic [3:0] MASK_HI_HALF = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

  // Unsigned widths exist only for loads, so funct3[2] on a store is illegal.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (is_store && f3[2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational store lane mask/replication and load lane
//            extraction with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [3:0]  store_mask,
  output logic [31:0] store_wdata,
  output logic [31:0] load_result
);

  logic [1:0]  offset;
  logic [31:0] shifted;

  // Halfwords ignore addr[0] and words ignore addr[1:0]: accesses align down.
  always_comb begin
    offset      = 2'b00;
    store_mask  = MASK_WORD;
    store_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        offset      = addr_lo;
        store_mask  = MASK_BYTE0 << addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        offset      = {addr_lo[1], 1'b0};
        store_mask  = addr_lo[1] ? MASK_HI_HALF : MASK_LO_HALF;
        store_wdata = {2{store_data[15:0]}};
      end
      default: begin
        offset      = 2'b00;
        store_mask  = MASK_WORD;
        store_wdata = store_data;
      end
    endcase
  end

  assign shifted = load_data >> {offset, 3'b000};

  always_comb begin
    load_result = shifted;
    case (funct3)
      F3_B:    load_result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_result = {24'd0, shifted[7:0]};
      F3_HU:   load_result = {16'd0, shifted[15:0]};
      default: load_result = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I memory stage: one aligned dmem word access per op, with
//            trap/fault reporting and extended load write-back.
//            Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [4:0]  i_rd,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_valid,
  output logic        o_done,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_rd,
  output logic        o_trap,
  output logic        o_fault
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

  lsu_state_t  state;
  logic [2:0]  op_funct3;
  logic [1:0]  op_addr_lo;
  logic [4:0]  op_rd;
  logic        op_is_load;
  logic [7:0]  wait_cnt;

  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic [3:0]  align_mask;
  logic [31:0] align_wdata;
  logic [31:0] align_load;
  logic        misaligned;
  logic        illegal;

  // In IDLE the aligner sees the incoming op; afterwards the captured one.
  assign sel_funct3  = (state == ST_IDLE) ? i_funct3    : op_funct3;
  assign sel_addr_lo = (state == ST_IDLE) ? i_addr[1:0] : op_addr_lo;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (i_is_load || i_is_store) &&
                      (((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign illegal = f3_illegal(i_funct3, i_is_store) || (i_is_load && i_is_store) || misaligned;

  lsu_align u_align (
    .funct3      (sel_funct3),
    .addr_lo     (sel_addr_lo),
    .store_data  (i_wdata),
    .load_data   (i_dmem_rdata),
    .store_mask  (align_mask),
    .store_wdata (align_wdata),
    .load_result (align_load)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      o_ready      <= 1'b1;
      o_dmem_addr  <= 32'd0;
      o_dmem_ren   <= 1'b0;
      o_dmem_wen   <= 1'b0;
      o_dmem_mask  <= MASK_NONE;
      o_dmem_wdata <= 32'd0;
      o_done       <= 1'b0;
      o_wb_valid   <= 1'b0;
      o_wb_data    <= 32'd0;
      o_wb_rd      <= 5'd0;
      o_trap       <= 1'b0;
      o_fault      <= 1'b0;
      op_funct3    <= 3'd0;
      op_addr_lo   <= 2'd0;
      op_rd        <= 5'd0;
      op_is_load   <= 1'b0;
      wait_cnt     <= 8'd0;
    end else begin
      // Strobes and pulses are single-cycle unless re-asserted below.
      o_done       <= 1'b0;
      o_wb_valid   <= 1'b0;
      o_trap       <= 1'b0;
      o_fault      <= 1'b0;
      o_dmem_ren   <= 1'b0;
      o_dmem_wen   <= 1'b0;
      o_dmem_mask  <= MASK_NONE;
      o_dmem_wdata <= 32'd0;

      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            o_ready    <= 1'b0;
            op_funct3  <= i_funct3;
            op_addr_lo <= i_addr[1:0];
            op_rd      <= i_rd;
            op_is_load <= i_is_load;
            if (illegal) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_trap <= 1'b1;
            end else if (!(i_is_load || i_is_store)) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state       <= ST_REQ;
              o_dmem_addr <= {i_addr[31:2], 2'b00};
              o_dmem_ren  <= i_is_load;
              o_dmem_wen  <= i_is_store;
              if (i_is_store) begin
                o_dmem_mask  <= align_mask;
                o_dmem_wdata <= align_wdata;
              end
            end
          end
        end

        ST_REQ: begin
          if (op_is_load) begin
            state    <= ST_WAIT;
            wait_cnt <= 8'd0;
          end else begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (i_dmem_valid) begin
            state      <= ST_DONE;
            o_done     <= 1'b1;
            o_wb_valid <= 1'b1;
            o_wb_data  <= align_load;
            o_wb_rd    <= op_rd;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ST_DONE;
            o_done  <= 1'b1;
            o_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
        end

        default: begin
          state   <= ST_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed vector bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  localparam int K_NONE  = 0;
  localparam int K_TRAP  = 1;
  localparam int K_STORE = 2;
  localparam int K_LOAD  = 3;
  localparam int NV      = 17;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          kind;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_is_load = 1'b0;
  logic        i_is_store = 1'b0;
  logic [4:0]  i_rd = '0;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_ren;
  logic        o_dmem_wen;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic [31:0] i_dmem_rdata = '0;
  logic        i_dmem_valid = 1'b0;
  logic        o_done;
  logic        o_wb_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_trap;
  logic        o_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_wb = 32'd0;
  logic [4:0]  last_rd = 5'd0;
  vec_t vecs [NV];

  load_store_unit #(.WAIT_LIMIT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_funct3(i_funct3),
    .i_is_load(i_is_load), .i_is_store(i_is_store), .i_rd(i_rd),
    .o_dmem_addr(o_dmem_addr), .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen),
    .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_valid(i_dmem_valid),
    .o_done(o_done), .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_trap(o_trap), .o_fault(o_fault)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata, input int kind,
                              input logic [31:0] ea, input logic [3:0] em,
                              input logic [31:0] ew, input logic [31:0] ewb);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.kind = kind; v.exp_addr = ea; v.exp_mask = em;
    v.exp_wdata = ew; v.exp_wb = ewb;
    return v;
  endfunction

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    i_is_load = ld; i_is_store = st; i_funct3 = f3;
    i_addr = addr; i_wdata = wdata; i_rd = rd; i_valid = 1'b1;
  endtask

  // Accept one op, answer loads with a bogus response during REQ and the real one a cycle later.
  task automatic run_vec(input int idx, input vec_t v);
    int done_cyc, ren_n, wen_n, exp_done;
    logic [31:0] q_addr, q_wdata, q_wbd;
    logic [3:0]  q_mask;
    logic [4:0]  q_wbr;
    logic        q_trap, q_fault, q_wbv;
    done_cyc = 0; ren_n = 0; wen_n = 0;
    q_addr = '0; q_wdata = '0; q_mask = '0; q_wbd = '0; q_wbr = '0;
    q_trap = 1'b0; q_fault = 1'b0; q_wbv = 1'b0;
    @(negedge i_clk);
    check($sformatf("v%0d ready_idle", idx), 32'(o_ready), 32'd1);
    drive_op(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    for (int c = 1; c <= 30 && done_cyc == 0; c++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      ren_n += int'(o_dmem_ren);
      wen_n += int'(o_dmem_wen);
      if (o_dmem_ren || o_dmem_wen) begin
        q_addr = o_dmem_addr; q_mask = o_dmem_mask; q_wdata = o_dmem_wdata;
      end
      if (o_done) begin
        done_cyc = c;
        q_trap = o_trap; q_fault = o_fault; q_wbv = o_wb_valid;
        q_wbd = o_wb_data; q_wbr = o_wb_rd;
      end
      i_dmem_valid = v.ld && (done_cyc == 0) && (c == 1 || c == 2);
      i_dmem_rdata = (c == 2) ? v.rdata : ~v.rdata;
    end
    i_dmem_valid = 1'b0;
    exp_done = (v.kind == K_STORE) ? 2 : (v.kind == K_LOAD) ? 3 : 1;
    check($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(exp_done));
    check($sformatf("v%0d ren_count", idx), 32'(ren_n), 32'(v.kind == K_LOAD));
    check($sformatf("v%0d wen_count", idx), 32'(wen_n), 32'(v.kind == K_STORE));
    check($sformatf("v%0d trap", idx), 32'(q_trap), 32'(v.kind == K_TRAP));
    check($sformatf("v%0d fault", idx), 32'(q_fault), 32'd0);
    check($sformatf("v%0d wb_valid", idx), 32'(q_wbv), 32'(v.kind == K_LOAD));
    if (v.kind == K_STORE || v.kind == K_LOAD) begin
      check($sformatf("v%0d dmem_addr", idx), q_addr, v.exp_addr);
      check($sformatf("v%0d dmem_mask", idx), 32'(q_mask), 32'(v.exp_mask));
      check($sformatf("v%0d dmem_wdata", idx), q_wdata, v.exp_wdata);
    end
    if (v.kind == K_LOAD) begin
      check($sformatf("v%0d wb_data", idx), q_wbd, v.exp_wb);
      check($sformatf("v%0d wb_rd", idx), 32'(q_wbr), 32'(v.rd));
      last_wb = v.exp_wb;
      last_rd = v.rd;
    end
    @(negedge i_clk);
    check($sformatf("v%0d ready_after", idx), 32'(o_ready), 32'd1);
    check($sformatf("v%0d done_pulse_width", idx), 32'(o_done), 32'd0);
  endtask

  initial begin
    int done_cyc, trap_cyc, ren_n, busy_ready, seen;
    logic q_fault, q_wbv, q_trap;
    logic [31:0] q_wbd;
    logic [4:0]  q_wbr;

    vecs[0]  = mk(0, 1, 3'b000, 32'h102, 32'h000000A5, 0, 0, K_STORE, 32'h100, 4'b0100, 32'hA5A5A5A5, 0);
    vecs[1]  = mk(0, 1, 3'b001, 32'h106, 32'h1234BEEF, 0, 0, K_STORE, 32'h104, 4'b1100, 32'hBEEFBEEF, 0);
    vecs[2]  = mk(0, 1, 3'b010, 32'h208, 32'hDEADBEEF, 0, 0, K_STORE, 32'h208, 4'b1111, 32'hDEADBEEF, 0);
    vecs[3]  = mk(0, 1, 3'b000, 32'h003, 32'h0000007F, 0, 0, K_STORE, 32'h000, 4'b1000, 32'h7F7F7F7F, 0);
    vecs[4]  = mk(1, 0, 3'b001, 32'h202, 0, 5'd5, 32'h80011234, K_LOAD, 32'h200, 4'b0000, 0, 32'hFFFF8001);
    vecs[5]  = mk(1, 0, 3'b101, 32'h202, 0, 5'd6, 32'h80011234, K_LOAD, 32'h200, 4'b0000, 0, 32'h00008001);
    vecs[6]  = mk(1, 0, 3'b000, 32'h201, 0, 5'd7, 32'h1234F07A, K_LOAD, 32'h200, 4'b0000, 0, 32'hFFFFFFF0);
    vecs[7]  = mk(1, 0, 3'b100, 32'h203, 0, 5'd8, 32'h9A345678, K_LOAD, 32'h200, 4'b0000, 0, 32'h0000009A);
    vecs[8]  = mk(1, 0, 3'b010, 32'h300, 0, 5'd31, 32'hCAFEF00D, K_LOAD, 32'h300, 4'b0000, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[9]  = mk(1, 0, 3'b010, 32'h301, 0, 5'd9, 32'h01234567, K_TRAP, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 3'b001, 32'h101, 32'hCAFE5A5A, 0, 0, K_TRAP, 0, 0, 0, 0);
`else
    vecs[9]  = mk(1, 0, 3'b010, 32'h301, 0, 5'd9, 32'h01234567, K_LOAD, 32'h300, 4'b0000, 0, 32'h01234567);
    vecs[14] = mk(0, 1, 3'b001, 32'h101, 32'hCAFE5A5A, 0, 0, K_STORE, 32'h100, 4'b0011, 32'h5A5A5A5A, 0);
`endif
    vecs[10] = mk(1, 0, 3'b011, 32'h400, 0, 5'd1, 0, K_TRAP, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 3'b100, 32'h400, 32'h11, 0, 0, K_TRAP, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 3'b010, 32'h400, 32'h22, 5'd2, 0, K_TRAP, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 3'b000, 32'h400, 32'h33, 5'd2, 0, K_NONE, 0, 0, 0, 0);
    vecs[15] = mk(0, 1, 3'b110, 32'h400, 32'h44, 0, 0, K_TRAP, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 3'b000, 32'h202, 0, 5'd10, 32'h00420000, K_LOAD, 32'h200, 4'b0000, 0, 32'h00000042);

    // Reset state
    repeat (2) @(negedge i_clk);
    check("reset ready", 32'(o_ready), 32'd1);
    check("reset strobes", {28'd0, o_dmem_ren, o_dmem_wen, o_done, o_wb_valid}, 32'd0);
    check("reset flags", {26'd0, o_trap, o_fault, o_dmem_mask}, 32'd0);
    check("reset addr", o_dmem_addr, 32'd0);
    check("reset wb_data", o_wb_data, 32'd0);
    i_rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Back-to-back: i_valid held through a load, then an illegal funct3 op waits for o_ready.
    @(negedge i_clk);
    drive_op(1, 0, 3'b010, 32'h500, 0, 5'd3);
    done_cyc = 0; trap_cyc = 0; ren_n = 0; busy_ready = 0; q_wbd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge i_clk);
      if (c == 1) begin i_funct3 = 3'b011; i_addr = 32'h600; i_rd = 5'd4; end
      ren_n += int'(o_dmem_ren);
      if (c <= 3 && o_ready) busy_ready++;
      if (o_done && !o_trap && done_cyc == 0) begin done_cyc = c; q_wbd = o_wb_data; end
      if (o_done && o_trap && trap_cyc == 0) trap_cyc = c;
      i_dmem_valid = (c == 2);
      i_dmem_rdata = 32'h13572468;
      if (trap_cyc != 0) i_valid = 1'b0;
    end
    i_dmem_valid = 1'b0;
    i_valid = 1'b0;
    check("b2b load done_cycle", 32'(done_cyc), 32'd3);
    check("b2b load wb_data", q_wbd, 32'h13572468);
    check("b2b ready while busy", 32'(busy_ready), 32'd0);
    check("b2b second trap cycle", 32'(trap_cyc), 32'd5);
    check("b2b ren count", 32'(ren_n), 32'd1);
    last_wb = 32'h13572468; last_rd = 5'd3;

    // Timeout: LB with no response.
    @(negedge i_clk);
    drive_op(1, 0, 3'b000, 32'h10, 0, 5'd12);
    done_cyc = 0; q_fault = 0; q_wbv = 0; q_trap = 0; q_wbd = '0; q_wbr = '0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (o_done) begin
        done_cyc = c; q_fault = o_fault; q_wbv = o_wb_valid; q_trap = o_trap;
        q_wbd = o_wb_data; q_wbr = o_wb_rd;
      end
    end
    check("timeout done_cycle", 32'(done_cyc), 32'd18);
    check("timeout fault", 32'(q_fault), 32'd1);
    check("timeout wb_valid", 32'(q_wbv), 32'd0);
    check("timeout trap", 32'(q_trap), 32'd0);
    check("timeout wb_data held", q_wbd, last_wb);
    check("timeout wb_rd held", 32'(q_wbr), 32'(last_rd));
    @(negedge i_clk);
    check("timeout ready after", 32'(o_ready), 32'd1);

    // Reset during WAIT, then a stray response.
    @(negedge i_clk);
    drive_op(1, 0, 3'b010, 32'h40, 0, 5'd14);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("rstwait ren in REQ", 32'(o_dmem_ren), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rstwait ready", 32'(o_ready), 32'd1);
    check("rstwait strobes", {28'd0, o_dmem_ren, o_dmem_wen, o_done, o_wb_valid}, 32'd0);
    check("rstwait flags", {26'd0, o_trap, o_fault, o_dmem_mask}, 32'd0);
    check("rstwait addr", o_dmem_addr, 32'd0);
    check("rstwait wb", {o_wb_data[26:0], o_wb_rd} | {27'd0, 5'd0} | o_wb_data, 32'd0);
    i_dmem_valid = 1'b1;
    i_dmem_rdata = 32'h55AA55AA;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      i_dmem_valid = 1'b0;
      if (o_done || o_wb_valid || o_dmem_ren || o_dmem_wen) seen++;
    end
    check("rstwait no completion", 32'(seen), 32'd0);
    check("rstwait wb_data stays", o_wb_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage that sits directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address, plus the store operand and funct3 width/sign code.
- Issues one aligned word access per instruction to the data memory port: byte-lane write mask on stores, lane extraction and sign/zero extension on loads.
- Multi-cycle, FSM-driven, valid/ready toward execute, request/response toward dmem; write-back result plus completion/trap/fault pulses.

Parameters:
- WAIT_LIMIT, default 16: max cycles in WAIT for i_dmem_valid before o_fault (range 1..255).

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  execute presents a memory op
- o_ready  out  1  LSU can accept (high only in IDLE)
- i_addr  in  32  effective address (ALU o_result)
- i_wdata  in  32  store data (rs2)
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- i_is_load  in  1  op is a load
- i_is_store  in  1  op is a store
- i_rd  in  5  load destination register
- o_dmem_addr  out  32  word address, {i_addr[31:2],2'b00}
- o_dmem_ren  out  1  read strobe, one cycle
- o_dmem_wen  out  1  write strobe, one cycle
- o_dmem_mask  out  4  byte-lane enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_rdata  in  32  read data, valid with i_dmem_valid
- i_dmem_valid  in  1  read response
- o_done  out  1  one-cycle completion pulse, every accepted op
- o_wb_valid  out  1  write-back valid, loads only, with o_done
- o_wb_data  out  32  extended load data
- o_wb_rd  out  5  registered i_rd
- o_trap  out  1  misaligned/illegal, with o_done
- o_fault  out  1  dmem timeout, with o_done

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Every output is registered.
- Reset values: state=IDLE; o_ready=1; all other outputs 0, including every strobe, pulse, mask, addr and data output. Reset in any state aborts the op and later i_dmem_valid is ignored.
- IDLE: if i_valid, capture all inputs and leave IDLE.
  - Illegal op goes to DONE with o_trap=1. Illegal means any of: funct3 in {011,110,111}; funct3[2]=1 on a store; load and store both set; misaligned (H with addr[0]=1, W with addr[1:0]!=0).
  - Neither load nor store goes to DONE, no access, no trap.
  - Otherwise go to REQ.
- REQ (1 cycle): drive o_dmem_addr and exactly one of ren/wen.
  - SB: mask=1<<addr[1:0], wdata={4{b}}.
  - SH: mask=addr[1]?1100:0011, wdata={2{h}}.
  - SW: mask=1111.
  - Loads drive mask=0000 and wdata=0.
  - Store then goes to DONE; load goes to WAIT.
- WAIT: sample i_dmem_valid from the first WAIT cycle onward (a response coincident with REQ is ignored).
  - On valid: shift rdata right by 8*addr[1:0], extend per funct3 (B/H sign-extend, BU/HU zero-extend, W as-is), go to DONE with o_wb_valid=1.
  - Counter cleared on entry. At WAIT_LIMIT cycles without valid, go to DONE with o_fault=1 and o_wb_valid=0.
- DONE (1 cycle): pulses valid for this cycle only, then IDLE. o_wb_data/o_wb_rd hold until the next load completes.
- Latency, accept at cycle T: trap T+1; store wen at T+1, done at T+2; load with valid at T+2 completes at T+3.
- o_ready=0 outside IDLE. i_valid while busy is not accepted; upstream holds. i_dmem_valid outside WAIT is ignored.

Optional Feature:
- LSU_MISALIGN_TRAP_EN.
  - Defined: misaligned H/W raise o_trap as above, with no memory access.
  - Undefined: misalignment is not checked. addr[0] is ignored for H and addr[1:0] for W; the access proceeds aligned down (e.g. LW at 0x1003 reads 0x1000). Illegal funct3 still traps.

Decomposition:
- Shared package lsu_pkg holds the funct3 width/sign encodings, FSM state encodings and the lane-mask constants.
- One natural sub-module, lsu_align: purely combinational store mask/replication and load lane extraction/extension, instantiated by load_store_unit.

Test Plan:
- SB addr=0x00000102, wdata=0x000000A5: REQ has mask=0100, wdata=0xA5A5A5A5, addr=0x100, wen=1 one cycle; o_done at T+2, o_wb_valid=0.
- LH addr=0x202, rdata=0x8001_1234 at T+2: o_wb_data=0xFFFF8001, o_wb_rd as given, o_done/o_wb_valid at T+3. Repeat with LHU: 0x00008001.
- LW addr=0x301 with LSU_MISALIGN_TRAP_EN: o_trap=1 and o_done=1 at T+1, no ren/wen ever. Without the macro: ren at addr=0x300.
- LB addr=0x10, no i_dmem_valid, WAIT_LIMIT=16: o_fault=1, o_done=1, o_wb_valid=0 after 16 WAIT cycles; o_ready returns next cycle.
- Reset asserted in WAIT, then i_dmem_valid pulse: all outputs zero, state IDLE, no o_done/o_wb_valid ever produced.
- Back-to-back: i_valid held through a load; second op accepted only when o_ready=1, after DONE. funct3=011 traps.
